// File: rtl/axis_hp_writer_pkg.sv
// Shared types and AXI constants for the AXI-Stream to HP-port DDR writer.
package axis_hp_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_t;

  localparam int          AXI_ID_W         = 6;
  localparam logic [1:0]  BURST_INCR       = 2'b01;
  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [3:0]  CACHE_BUFFERABLE = 4'b0011;

  function automatic logic [31:0] beats_to_bytes(input logic [8:0] beats,
                                                 input int unsigned beat_bytes);
    return 32'(beats) * 32'(beat_bytes);
  endfunction

endpackage

// File: rtl/axis_hp_writer.sv
// Writes cfg_len stream beats to DDR as INCR bursts, one burst outstanding at a time.
// Latency: AW one cycle after start; stream backpressure is WREADY passed straight through.
module axis_hp_writer
  import axis_hp_writer_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [23:0]         cfg_len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         beats_written,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [AXI_ID_W-1:0] m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  output logic                m_axi_rready
);

  localparam int unsigned       BEAT_BYTES = DATA_W / 8;
  localparam int                ALIGN_BITS = $clog2(BURST_BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN_BITS;

  logic [1:0]        rst_pipe;
  logic              rst_int_n;
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       remaining;
  logic [7:0]        awlen_q, awlen_c, beat_cnt;
  logic              zero_done;
  logic              start_ok, aw_hs, w_hs, b_hs;

  // Assert asynchronously, release on a registered edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  assign start_ok = start && (state == ST_IDLE);
  assign aw_hs    = m_axi_awvalid && m_axi_awready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign b_hs     = m_axi_bvalid && m_axi_bready;
  assign awlen_c  = (remaining >= 24'(BURST_BEATS)) ? 8'(BURST_BEATS - 1)
                                                    : 8'(remaining - 24'd1);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok && cfg_len != '0) state_nxt = ST_AW;
      ST_AW:   if (aw_hs) state_nxt = ST_W;
      ST_W:    if (w_hs && m_axi_wlast) state_nxt = ST_B;
      ST_B:    if (b_hs) state_nxt = (remaining != '0) ? ST_AW : ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    s_axis_tready = 1'b0;
    busy          = (state != ST_IDLE);
    done          = (state == ST_DONE) || zero_done;
    case (state)
      ST_AW: m_axi_awvalid = 1'b1;
      ST_W: begin
        m_axi_wvalid  = s_axis_tvalid;
        s_axis_tready = m_axi_wready;
        m_axi_wlast   = (beat_cnt == awlen_q);
      end
      ST_B:  m_axi_bready = 1'b1;
      default: ;
    endcase
  end

  // Remaining is charged at AW acceptance so AWLEN stays stable while AWVALID is up.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      addr_q        <= '0;
      remaining     <= '0;
      awlen_q       <= '0;
      beat_cnt      <= '0;
      err           <= 1'b0;
      beats_written <= '0;
      zero_done     <= 1'b0;
    end else begin
      zero_done <= start_ok && (cfg_len == '0);
      if (start_ok) begin
        addr_q        <= cfg_addr & ALIGN_MASK;
        remaining     <= cfg_len;
        beat_cnt      <= '0;
        err           <= 1'b0;
        beats_written <= '0;
      end
      if (aw_hs) begin
        awlen_q   <= awlen_c;
        remaining <= remaining - (24'(awlen_c) + 24'd1);
      end
      if (w_hs) begin
        beats_written <= beats_written + 32'd1;
        beat_cnt      <= m_axi_wlast ? 8'd0 : beat_cnt + 8'd1;
      end
      if (b_hs) begin
        addr_q <= addr_q + ADDR_W'(beats_to_bytes(9'(awlen_q) + 9'd1, BEAT_BYTES));
        if (m_axi_bresp != RESP_OKAY) err <= 1'b1;
      end
    end
  end

  assign m_axi_awid    = '0;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_c;
  assign m_axi_awsize  = 3'($clog2(BEAT_BYTES));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_BUFFERABLE;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_araddr  = '0;
  assign m_axi_arvalid = 1'b0;
  assign m_axi_rready  = 1'b0;

endmodule

// File: tb/tb_axis_hp_writer.sv
// Directed bench for axis_hp_writer with a scoreboard-driven AXI write slave.
module tb_axis_hp_writer;

  logic        clk, rst_n, start;
  logic [31:0] cfg_addr;
  logic [23:0] cfg_len;
  logic        busy, done, err;
  logic [31:0] beats_written;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;
  logic [5:0]  awid;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, wstrb;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, bresp;
  logic [3:0]  awcache, awqos;
  logic        awlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [63:0] wdata;
  logic        arvalid, rready;

  axis_hp_writer #(.ADDR_W(32), .DATA_W(64), .BURST_BEATS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err(err), .beats_written(beats_written),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
    .m_axi_arvalid(arvalid), .m_axi_rready(rready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [63:0] data; logic last; } w_exp_t;

  aw_exp_t exp_aw[$];
  w_exp_t  exp_w[$];

  int checks = 0;
  int errors = 0;
  bit stall_en = 0;
  int slverr_target = -1;
  int w_last_total = 0, b_hs_total = 0, done_cnt = 0;
  int b_issued = 0, b_acked = 0;
  logic        err_at_done;
  logic [31:0] bw_at_done;
  bit          aw_stalled = 0;
  logic [31:0] aw_hold_addr;
  logic [7:0]  aw_hold_len;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave: ready/response changes just after the clock edge.
  initial begin
    awready = 1; wready = 1; bvalid = 0; bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      awready = stall_en ? ($urandom_range(0, 2) == 0) : 1'b1;
      wready  = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!rst_n) begin
        bvalid   = 0;
        b_issued = w_last_total;
        b_acked  = b_hs_total;
      end else begin
        if (bvalid && b_hs_total != b_acked) begin
          bvalid  = 0;
          b_acked = b_hs_total;
        end
        if (!bvalid && w_last_total > b_issued && (!stall_en || $urandom_range(0, 1) == 1)) begin
          bresp    = (b_issued == slverr_target) ? 2'b10 : 2'b00;
          bvalid   = 1;
          b_issued++;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, compares against the scoreboard queues.
  initial begin
    aw_exp_t ea;
    w_exp_t  ew;
    forever begin
      @(negedge clk);
      if (awvalid && aw_stalled) begin
        chk("aw_stable_addr", awaddr, aw_hold_addr);
        chk("aw_stable_len", awlen, aw_hold_len);
      end
      if (awvalid && awready) begin
        aw_stalled = 0;
        if (exp_aw.size() == 0) begin
          checks++; errors++;
          $display("FAIL aw_unexpected: got addr 0x%0h len %0d, expected no burst", awaddr, awlen);
        end else begin
          ea = exp_aw.pop_front();
          chk("awaddr", awaddr, ea.addr);
          chk("awlen", awlen, ea.len);
          chk("awsize_burst_cache", {awsize, awburst, awcache}, {3'd3, 2'b01, 4'b0011});
        end
      end else if (awvalid) begin
        aw_stalled   = 1;
        aw_hold_addr = awaddr;
        aw_hold_len  = awlen;
      end else begin
        aw_stalled = 0;
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_unexpected: got data 0x%0h, expected no beat", wdata);
        end else begin
          ew = exp_w.pop_front();
          chk("wdata", wdata, ew.data);
          chk("wlast", wlast, ew.last);
          chk("wstrb", wstrb, 8'hff);
        end
        if (wlast) w_last_total++;
      end
      if (bvalid && bready) b_hs_total++;
      if (done) begin
        done_cnt++;
        err_at_done = err;
        bw_at_done  = beats_written;
      end
    end
  end

  task automatic push_aw(input logic [31:0] addr, input logic [7:0] len);
    aw_exp_t e;
    e.addr = addr;
    e.len  = len;
    exp_aw.push_back(e);
  endtask

  task automatic push_w(input int n, input logic [63:0] base);
    w_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = base + 64'(i);
      e.last = ((i % 16) == 15) || (i == n - 1);
      exp_w.push_back(e);
    end
  endtask

  task automatic send_stream(input int n, input logic [63:0] base, input bit gaps);
    int t;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_axis_tvalid = 0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      s_axis_tdata  = base + 64'(i);
      s_axis_tvalid = 1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!s_axis_tready && t < 2000);
      if (!s_axis_tready) begin
        checks++; errors++;
        $display("FAIL stream_timeout: beat %0d not accepted, expected tready", i);
        s_axis_tvalid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    s_axis_tvalid = 0;
  endtask

  task automatic run_xfer(input logic [31:0] addr, input int len, input logic [63:0] base,
                          input bit gaps, input logic exp_err);
    int d0, t;
    d0 = done_cnt;
    push_w(len, base);
    @(posedge clk); #1;
    cfg_addr = addr;
    cfg_len  = 24'(len);
    start    = 1;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    chk("err_cleared", err, 1'b0);
    if (len != 0) begin
      chk("busy_after_start", busy, 1'b1);
    end else begin
      chk("zero_busy", busy, 1'b0);
      chk("zero_done_pulse", done, 1'b1);
    end
    send_stream(len, base, gaps);
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("beats_at_done", bw_at_done, 32'(len));
    chk("err_at_done", err_at_done, exp_err);
    chk("beats_hold", beats_written, 32'(len));
    chk("busy_idle", busy, 1'b0);
    chk("aw_queue_empty", 32'(exp_aw.size()), 32'd0);
    chk("w_queue_empty", 32'(exp_w.size()), 32'd0);
  endtask

  initial begin
    int wl0;
    rst_n = 0; start = 0; cfg_addr = '0; cfg_len = '0;
    s_axis_tvalid = 0; s_axis_tdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_outs", {err, s_axis_tready, awvalid, wvalid, wlast, bready, arvalid, rready}, 8'h00);
    chk("rst_beats", beats_written, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (4) @(posedge clk);

    push_aw(32'h1000_0000, 8'd15);
    push_aw(32'h1000_0080, 8'd15);
    push_aw(32'h1000_0100, 8'd7);
    run_xfer(32'h1000_0000, 40, 64'hA000_0000, 0, 1'b0);

    push_aw(32'h1000_0000, 8'd15);
    run_xfer(32'h1000_0044, 16, 64'hB000_0000, 0, 1'b0);

    run_xfer(32'h1000_0000, 0, 64'h0, 0, 1'b0);

    stall_en = 1;
    wl0 = w_last_total;
    push_aw(32'h0800_0000, 8'd15);
    push_aw(32'h0800_0080, 8'd15);
    push_aw(32'h0800_0100, 8'd0);
    run_xfer(32'h0800_0000, 33, 64'hC000_0000, 1, 1'b0);
    chk("wlast_count", 32'(w_last_total - wl0), 32'd3);
    stall_en = 0;

    slverr_target = b_issued + 1;
    push_aw(32'h2000_0000, 8'd15);
    push_aw(32'h2000_0080, 8'd15);
    push_aw(32'h2000_0100, 8'd7);
    run_xfer(32'h2000_0000, 40, 64'hD000_0000, 0, 1'b1);
    chk("err_sticky", err, 1'b1);
    slverr_target = -1;
    push_aw(32'h2000_1000, 8'd15);
    run_xfer(32'h2000_1000, 16, 64'hD100_0000, 0, 1'b0);

    // Abort part way through the first burst.
    begin
      w_exp_t e;
      for (int i = 0; i < 5; i++) begin
        e.data = 64'hE000_0000 + 64'(i);
        e.last = 1'b0;
        exp_w.push_back(e);
      end
    end
    push_aw(32'h2800_0000, 8'd15);
    @(posedge clk); #1;
    cfg_addr = 32'h2800_0000; cfg_len = 24'd32; start = 1;
    @(posedge clk); #1;
    start = 0;
    send_stream(5, 64'hE000_0000, 0);
    #2 rst_n = 0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_outs", {err, s_axis_tready, awvalid, wvalid, wlast, bready}, 6'h00);
    chk("abort_beats", beats_written, 32'd0);
    chk("abort_queues", 32'(exp_aw.size() + exp_w.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (4) @(posedge clk);
    chk("abort_idle", busy, 1'b0);

    push_aw(32'h3000_0000, 8'd15);
    push_aw(32'h3000_0080, 8'd3);
    run_xfer(32'h3000_0000, 20, 64'hF000_0000, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
